// File: rtl/fpmul_seq_if.sv
// Operand, result and status bundle between the execute stage and the multiply sequencer.
// The slave side is the sequencer; the master side is the requester plus the multiplier.
interface fpmul_seq_if;
  logic        start;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        clear_flags;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_result;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        res_n;
  logic        res_z;
  logic [2:0]  flags;

  modport slave (
    input  start, srca, srcb, clear_flags, mul_result,
    output mul_a, mul_b, busy, done, result, res_n, res_z, flags
  );

  modport master (
    output start, srca, srcb, clear_flags, mul_result,
    input  mul_a, mul_b, busy, done, result, res_n, res_z, flags
  );
endinterface

// File: rtl/fpmul_seq.sv
// Multicycle sequencer for the combinational single-precision multiplier: latches operands,
// waits LATENCY cycles for the product to settle, then registers it with status and sticky flags.
module fpmul_seq #(
  parameter int unsigned LATENCY = 1  // legal range 1..15
) (
  input logic         clk,
  input logic         reset,
  fpmul_seq_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] v);
    return v[30:0] == 31'd0;
  endfunction

  logic [1:0]  state_q,  state_d;
  logic [3:0]  cnt_q,    cnt_d;
  logic [31:0] mul_a_q,  mul_a_d;
  logic [31:0] mul_b_q,  mul_b_d;
  logic [31:0] result_q, result_d;
  logic        res_n_q,  res_n_d;
  logic        res_z_q,  res_z_d;
  logic [2:0]  flags_q,  flags_d;

  logic        load_ops;
  logic        capture;
  logic        a_fin, b_fin;
  logic        flag_inv, flag_ovf, flag_unf;
  logic [2:0]  flags_base;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_ops = 1'b0;
    capture  = 1'b0;
    case (state_q)
      StIdle: load_ops = bus.start;
      StExec: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          capture = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        load_ops = bus.start;
        if (!bus.start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (load_ops) begin
      cnt_d   = CntInit;
      state_d = StExec;
    end
  end

  // Classification looks at the latched operands, which stay stable until the capture edge.
  always_comb begin
    a_fin    = mul_a_q[30:23] != 8'hFF;
    b_fin    = mul_b_q[30:23] != 8'hFF;
    flag_inv = is_nan(mul_a_q) || is_nan(mul_b_q) ||
               (is_zero(mul_a_q) && is_inf(mul_b_q)) ||
               (is_inf(mul_a_q) && is_zero(mul_b_q));
    flag_ovf = is_inf(bus.mul_result) && a_fin && b_fin;
    flag_unf = a_fin && b_fin && !is_zero(mul_a_q) && !is_zero(mul_b_q) &&
               (bus.mul_result[30:23] == 8'h00);
  end

  always_comb begin
    mul_a_d    = load_ops ? bus.srca : mul_a_q;
    mul_b_d    = load_ops ? bus.srcb : mul_b_q;
    result_d   = result_q;
    res_n_d    = res_n_q;
    res_z_d    = res_z_q;
    // A clear coinciding with a capture drops old flags but keeps the new event.
    flags_base = bus.clear_flags ? 3'b000 : flags_q;
    flags_d    = flags_base;
    if (capture) begin
      result_d = bus.mul_result;
      res_n_d  = bus.mul_result[31] & ~is_nan(bus.mul_result);
      res_z_d  = is_zero(bus.mul_result);
      flags_d  = flags_base | {flag_inv, flag_ovf, flag_unf};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      mul_a_q  <= 32'd0;
      mul_b_q  <= 32'd0;
      result_q <= 32'd0;
      res_n_q  <= 1'b0;
      res_z_q  <= 1'b0;
      flags_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      result_q <= result_d;
      res_n_q  <= res_n_d;
      res_z_q  <= res_z_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.mul_a  = mul_a_q;
  assign bus.mul_b  = mul_b_q;
  assign bus.busy   = (state_q == StExec);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.res_n  = res_n_q;
  assign bus.res_z  = res_z_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_fpmul_seq.sv
// Bench for fpmul_seq: one instance at LATENCY=1, one at LATENCY=4, each fed by a behavioural
// round-to-nearest-even single-precision multiplier; results checked through a scoreboard queue.
module tb_fpmul_seq;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flg;
    logic        n;
    logic        z;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  clr;  // 0 none, 1 clear pulse before start, 2 clear on the capture cycle
    logic [31:0] res;
    logic [2:0]  flg;
    logic        n;
    logic        z;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        clear_flags;
  logic [31:0] srca, srcb;
  logic        sel;  // 0 drives/observes the LATENCY=1 instance, 1 the LATENCY=4 instance

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  vec_t vecs[0:8];
  int   nb;
  int   dn;
  bit   seen;

  always #5 clk = ~clk;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e, sh;
    logic [23:0] ma, mb;
    logic [47:0] p;
    logic [24:0] m;
    logic        g, st;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a | 32'h0040_0000;
    if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b | 32'h0040_0000;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return 32'h7FC0_0000;
      return {s, 8'hFF, 23'd0};
    end
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    ma = {a[30:23] != 8'd0, a[22:0]};
    mb = {b[30:23] != 8'd0, b[22:0]};
    for (int i = 0; i < 23 && !ma[23]; i++) begin ma = ma << 1; ea--; end
    for (int i = 0; i < 23 && !mb[23]; i++) begin mb = mb << 1; eb--; end
    e = ea + eb - 127;
    p = 48'(ma) * 48'(mb);
    if (p[47]) e++;
    else p = p << 1;
    st = 1'b0;
    if (e < 1) begin
      sh = 1 - e;
      if (sh > 49) sh = 49;
      for (int i = 0; i < sh; i++) begin st = st | p[0]; p = p >> 1; end
      e = 1;
    end
    m  = {1'b0, p[47:24]};
    g  = p[23];
    st = st | (|p[22:0]);
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e++; end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, (m[23] ? 8'(e) : 8'h00), m[22:0]};
  endfunction

  fpmul_seq_if u_if1 ();
  fpmul_seq_if u_if4 ();

  assign u_if1.start       = start & ~sel;
  assign u_if4.start       = start & sel;
  assign u_if1.clear_flags = clear_flags & ~sel;
  assign u_if4.clear_flags = clear_flags & sel;
  assign u_if1.srca        = srca;
  assign u_if1.srcb        = srcb;
  assign u_if4.srca        = srca;
  assign u_if4.srcb        = srcb;
  assign u_if1.mul_result  = fmul(u_if1.mul_a, u_if1.mul_b);
  assign u_if4.mul_result  = fmul(u_if4.mul_a, u_if4.mul_b);

  fpmul_seq #(.LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(u_if1.slave));
  fpmul_seq #(.LATENCY(4)) u_dut4 (.clk(clk), .reset(reset), .bus(u_if4.slave));

  logic        o_busy, o_done, o_n, o_z;
  logic [31:0] o_result, o_mul_a, o_mul_b;
  logic [2:0]  o_flags;

  assign o_busy   = sel ? u_if4.busy   : u_if1.busy;
  assign o_done   = sel ? u_if4.done   : u_if1.done;
  assign o_n      = sel ? u_if4.res_n  : u_if1.res_n;
  assign o_z      = sel ? u_if4.res_z  : u_if1.res_z;
  assign o_result = sel ? u_if4.result : u_if1.result;
  assign o_mul_a  = sel ? u_if4.mul_a  : u_if1.mul_a;
  assign o_mul_b  = sel ? u_if4.mul_b  : u_if1.mul_b;
  assign o_flags  = sel ? u_if4.flags  : u_if1.flags;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic [31:0] r, input logic [2:0] f, input logic n,
                                  input logic z);
    exp_t e;
    e.res = r;
    e.flg = f;
    e.n   = n;
    e.z   = z;
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && o_done) begin
      chk("busy_done_exclusive", 32'(o_busy), 32'd0);
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1, expected no pending op (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", o_result, e.res);
        chk("flags", 32'(o_flags), 32'(e.flg));
        chk("res_n", 32'(o_n), 32'(e.n));
        chk("res_z", 32'(o_z), 32'(e.z));
      end
    end
  end

  task automatic check_reset();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_mul_a", o_mul_a, 32'd0);
    chk("rst_mul_b", o_mul_b, 32'd0);
    chk("rst_flags", 32'(o_flags), 32'd0);
    chk("rst_res_n", 32'(o_n), 32'd0);
    chk("rst_res_z", 32'(o_z), 32'd0);
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] clr,
                       input int lat, input exp_t e);
    int busy_cnt;
    bit got;
    if (clr == 2'd1) begin
      clear_flags = 1'b1;
      @(posedge clk); #1 clear_flags = 1'b0;
      @(negedge clk);
      chk("flags_after_clear", 32'(o_flags), 32'd0);
      @(posedge clk); #1;
    end
    sb_q.push_back(e);
    srca  = a;
    srcb  = b;
    start = 1'b1;
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      start       = 1'b0;
      srca        = 32'hDEAD_BEEF;
      srcb        = 32'h0BAD_F00D;
      clear_flags = (clr == 2'd2) && (i == 0);
      @(negedge clk);
      if (o_done) got = 1'b1;
      else if (o_busy) busy_cnt++;
    end
    clear_flags = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'(lat));
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{32'h4000_0000, 32'h4040_0000, 2'd1, 32'h40C0_0000, 3'b000, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h7F80_0000, 2'd0, 32'h7FC0_0000, 3'b100, 1'b0, 1'b0};
    vecs[2] = '{32'h7F7F_FFFF, 32'h3F80_0001, 2'd1, 32'h7F80_0000, 3'b010, 1'b0, 1'b0};
    vecs[3] = '{32'hFF7F_FFFF, 32'h3F80_0001, 2'd0, 32'hFF80_0000, 3'b010, 1'b1, 1'b0};
    vecs[4] = '{32'hC000_0000, 32'h4040_0000, 2'd1, 32'hC0C0_0000, 3'b000, 1'b1, 1'b0};
    vecs[5] = '{32'h0080_0000, 32'h3F00_0000, 2'd0, 32'h0040_0000, 3'b001, 1'b0, 1'b0};
    vecs[6] = '{32'h0080_0000, 32'h0080_0000, 2'd0, 32'h0000_0000, 3'b001, 1'b0, 1'b1};
    vecs[7] = '{32'h7FC0_0001, 32'h3F80_0000, 2'd2, 32'h7FC0_0001, 3'b100, 1'b0, 1'b0};
    vecs[8] = '{32'hFFC0_0000, 32'h3F80_0000, 2'd0, 32'hFFC0_0000, 3'b100, 1'b0, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    clear_flags = 1'b0;
    srca = 32'd0;
    srcb = 32'd0;
    sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].clr, 1,
            mk_exp(vecs[i].res, vecs[i].flg, vecs[i].n, vecs[i].z));
    end

    // LATENCY=4: start held through EXEC is ignored, then a back-to-back start from DONE.
    sel = 1'b1;
    @(posedge clk); #1;
    sb_q.push_back(mk_exp(32'h3FC0_0000, 3'b000, 1'b0, 1'b0));
    srca  = 32'h4040_0000;
    srcb  = 32'h3F00_0000;
    start = 1'b1;
    @(posedge clk); #1;
    srca = 32'h7F80_0000;
    srcb = 32'h0000_0000;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
      else if (o_busy) nb++;
    end
    chk("b2b_first_done", 32'(seen), 32'd1);
    chk("b2b_first_busy", 32'(nb), 32'd4);
    chk("b2b_mul_a_held", o_mul_a, 32'h4040_0000);
    sb_q.push_back(mk_exp(32'h8000_0000, 3'b000, 1'b1, 1'b1));
    srca = 32'hBF80_0000;
    srcb = 32'h0000_0000;
    @(posedge clk); #1 start = 1'b0;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
      else if (o_busy) nb++;
    end
    chk("b2b_second_done", 32'(seen), 32'd1);
    chk("b2b_second_busy", 32'(nb), 32'd4);
    @(posedge clk); #1;

    // Reset on the second EXEC cycle discards the pending invalid operation.
    srca  = 32'h7F80_0000;
    srcb  = 32'h0000_0000;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset();
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    chk("no_done_after_reset", 32'(dn), 32'd0);
    @(posedge clk); #1;
    do_op(32'h4000_0000, 32'h4040_0000, 2'd0, 4, mk_exp(32'h40C0_0000, 3'b000, 1'b0, 1'b0));

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
